// File: rtl/presc_pkg.sv
// Shared types and defaults for the prescaler arbiter family.
package presc_pkg;

  localparam int unsigned PrescMaxDefault = 256;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRun,
    StRelease
  } arb_state_e;

endpackage

// File: rtl/mod_rr_pick.sv
// Combinational round-robin picker: selects the first active request after index last,
// wrapping modulo NUM_REQ. Reusable by any arbiter that keeps its own last-owner register.
module mod_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  int unsigned cand;
  logic [IW-1:0] cidx;
  logic found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = |req;
    cand   = 0;
    cidx   = '0;
    found  = 1'b0;
    // Offset 1 is checked first so the previous owner has lowest priority.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last) + i) % NUM_REQ;
      cidx = IW'(cand);
      if (!found && req[cidx]) begin
        found        = 1'b1;
        idx          = cidx;
        onehot       = '0;
        onehot[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_presc_arb.sv
// Round-robin arbiter sharing one programmable tick generator among NUM_REQ requesters.
// Define PRESC_ARB_TIMEOUT_EN to force a release after TIMEOUT_TICKS ticks per grant.
module mod_presc_arb
  import presc_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned PRESC_MAX     = PrescMaxDefault,
  parameter int unsigned TIMEOUT_TICKS = 64,
  localparam int unsigned PW           = $clog2(PRESC_MAX) + 1,
  localparam int unsigned IW           = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*PW-1:0] presc_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic                  tick_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam logic [PW-1:0] DivMax = PW'(PRESC_MAX - 1);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] owner_oh_q, owner_oh_d;
  logic [IW-1:0]      last_q, last_d;
  logic [PW-1:0]      div_q, div_d;
  logic [PW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      presc_sel;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               owner_req;

`ifdef PRESC_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          forced_q, forced_d;
`else
  logic unused_timeout_ticks;
  assign unused_timeout_ticks = ^TIMEOUT_TICKS;
`endif

  mod_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_rr_pick (
    .req   (req_i),
    .last  (last_q),
    .onehot(pick_oh),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign owner_req = |(req_i & owner_oh_q);

  always_comb begin
    presc_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_oh_q[i]) presc_sel = presc_i[i*PW +: PW];
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    last_d     = last_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    gnt_o      = '0;
    tick_o     = 1'b0;
    busy_o     = (state_q != StIdle);
    timeout_o  = 1'b0;
`ifdef PRESC_ARB_TIMEOUT_EN
    tcnt_d     = tcnt_q;
    forced_d   = forced_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d    = pick_idx;
          owner_oh_d = pick_oh;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        gnt_o   = owner_oh_q;
        div_d   = (presc_sel > DivMax) ? DivMax : presc_sel;
        cnt_d   = '0;
        state_d = StRun;
`ifdef PRESC_ARB_TIMEOUT_EN
        tcnt_d   = '0;
        forced_d = 1'b0;
`endif
      end
      StRun: begin
        gnt_o = owner_oh_q;
        // A dropping request wins over a coinciding terminal count: no tick.
        if (!owner_req) begin
          state_d = StRelease;
        end else if (cnt_q == div_q) begin
          tick_o = 1'b1;
          cnt_d  = '0;
`ifdef PRESC_ARB_TIMEOUT_EN
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == TW'(TIMEOUT_TICKS - 1)) begin
            state_d  = StRelease;
            forced_d = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        cnt_d   = '0;
        last_d  = owner_q;
        state_d = StIdle;
`ifdef PRESC_ARB_TIMEOUT_EN
        timeout_o = forced_q;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      owner_oh_q <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      div_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      last_q     <= last_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef PRESC_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcnt_q   <= '0;
      forced_q <= 1'b0;
    end else begin
      tcnt_q   <= tcnt_d;
      forced_q <= forced_d;
    end
  end
`endif

endmodule

// File: tb/tb_mod_presc_arb.sv
// Scoreboard bench for mod_presc_arb: stimulus queues expected grant/tick/timeout cycles,
// a negedge monitor pops and compares them. Define PRESC_ARB_TIMEOUT_EN for the timeout run.
module tb_mod_presc_arb;

  localparam int unsigned NR   = 4;
  localparam int unsigned PMAX = 256;
  localparam int unsigned PW   = $clog2(PMAX) + 1;
`ifdef PRESC_ARB_TIMEOUT_EN
  localparam int unsigned TOT = 4;
`else
  localparam int unsigned TOT = 64;
`endif

  logic             clk_i   = 1'b0;
  logic             rst_i   = 1'b0;
  logic [NR-1:0]    req_i   = '0;
  logic [NR*PW-1:0] presc_i = '0;
  logic [NR-1:0]    gnt_o;
  logic             tick_o;
  logic             busy_o;
  logic             timeout_o;

  mod_presc_arb #(
    .NUM_REQ      (NR),
    .PRESC_MAX    (PMAX),
    .TIMEOUT_TICKS(TOT)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .presc_i  (presc_i),
    .gnt_o    (gnt_o),
    .tick_o   (tick_o),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {int c; int gnt;} gnt_exp_t;
  typedef struct {int c; int gnt; int busy;} snap_t;

  gnt_exp_t exp_gnt[$];
  int       exp_tick[$];
  int       exp_to[$];
  snap_t    exp_snap[$];
  bit       done = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_gnt(input int c, input int v);
    gnt_exp_t e;
    e.c = c;
    e.gnt = v;
    exp_gnt.push_back(e);
  endtask

  task automatic push_snap(input int c, input int g, input int b);
    snap_t s;
    s.c = c;
    s.gnt = g;
    s.busy = b;
    exp_snap.push_back(s);
  endtask

  task automatic set_presc(input int i, input int v);
    presc_i[i*PW +: PW] = PW'(v);
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Monitor: the only process that compares and counts.
  logic [NR-1:0] gnt_prev = '0;
  gnt_exp_t ge;
  snap_t    se;
  int       te;
  always @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      #1;
      cmp("rst_gnt", int'(gnt_o), 0);
      cmp("rst_tick", int'(tick_o), 0);
      cmp("rst_busy", int'(busy_o), 0);
      cmp("rst_timeout", int'(timeout_o), 0);
      gnt_prev = '0;
    end else begin
      if (gnt_o != '0 && gnt_prev == '0) begin
        cmp("grant_onehot", int'($onehot(gnt_o)), 1);
        if (exp_gnt.size() == 0) cmp("grant_unexpected_cycle", cyc, -1);
        else begin
          ge = exp_gnt.pop_front();
          cmp("grant_cycle", cyc, ge.c);
          cmp("grant_vec", int'(gnt_o), ge.gnt);
        end
      end
      gnt_prev = gnt_o;
      if (tick_o) begin
        if (exp_tick.size() == 0) cmp("tick_unexpected_cycle", cyc, -1);
        else begin
          te = exp_tick.pop_front();
          cmp("tick_cycle", cyc, te);
        end
      end
      if (timeout_o) begin
        if (exp_to.size() == 0) cmp("timeout_unexpected_cycle", cyc, -1);
        else begin
          te = exp_to.pop_front();
          cmp("timeout_cycle", cyc, te);
        end
      end
      while (exp_snap.size() > 0 && exp_snap[0].c <= cyc) begin
        se = exp_snap.pop_front();
        cmp("snap_cycle", cyc, se.c);
        cmp("snap_gnt", int'(gnt_o), se.gnt);
        cmp("snap_busy", int'(busy_o), se.busy);
      end
      if (done) begin
        cmp("grants_left", exp_gnt.size(), 0);
        cmp("ticks_left", exp_tick.size(), 0);
        cmp("timeouts_left", exp_to.size(), 0);
        cmp("snaps_left", exp_snap.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int g;
    #1 rst_i = 1'b1;
    goto(3);
    rst_i = 1'b0;

    // Scenario 1: single requester, divider 3.
    set_presc(0, 3);
    req_i = 4'b0001;
    g = cyc + 1;
    push_gnt(g, 1);
    exp_tick.push_back(g + 4);
    exp_tick.push_back(g + 8);
    exp_tick.push_back(g + 12);
    push_snap(g + 14, 0, 1);
    push_snap(g + 15, 0, 0);
    goto(g + 13);
    req_i = '0;
    goto(g + 16);

    rst_i = 1'b1;
    goto(cyc + 2);
    rst_i = 1'b0;
    goto(cyc + 1);

    // Scenario 2: all request, each owner drops after 2 ticks.
    for (int i = 0; i < 4; i++) set_presc(i, 1);
    req_i = 4'b1111;
    g = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      push_gnt(g + 8*k, 1 << (k % 4));
      exp_tick.push_back(g + 8*k + 2);
      exp_tick.push_back(g + 8*k + 4);
      push_snap(g + 8*k + 6, 0, 1);
    end
    for (int k = 0; k < 5; k++) begin
      goto(g + 8*k + 5);
      if (k < 4) begin
        req_i[k % 4] = 1'b0;
        goto(g + 8*k + 6);
        req_i[k % 4] = 1'b1;
      end else begin
        req_i = '0;
      end
    end
    goto(g + 40);

    // Scenario 5: reset mid-RUN, then requester 0 must win over 1.
    set_presc(2, 0);
    req_i = 4'b0100;
    g = cyc + 1;
    push_gnt(g, 4);
    exp_tick.push_back(g + 1);
    exp_tick.push_back(g + 2);
    goto(g + 3);
    #2 rst_i = 1'b1;
    req_i = 4'b0011;
    set_presc(0, 1);
    goto(cyc + 2);
    rst_i = 1'b0;
    g = cyc + 1;
    push_gnt(g, 1);
    push_snap(g + 3, 0, 1);
    goto(g + 2);
    req_i = '0;
    goto(g + 5);

    // Scenario 3: divider 0 ticks every RUN cycle; later presc change ignored.
    set_presc(1, 0);
    req_i = 4'b0010;
    g = cyc + 1;
    push_gnt(g, 2);
    for (int k = 1; k <= 3; k++) exp_tick.push_back(g + k);
    push_snap(g + 5, 0, 1);
    goto(g + 2);
    set_presc(1, 5);
    goto(g + 4);
    req_i = '0;
    goto(g + 7);

    // Saturation: 511 is latched as 255.
    set_presc(2, 511);
    req_i = 4'b0100;
    g = cyc + 1;
    push_gnt(g, 4);
    exp_tick.push_back(g + 256);
    push_snap(g + 258, 0, 1);
    goto(g + 257);
    req_i = '0;
    goto(g + 260);

    // Scenario 4: request drops on the terminal-count cycle.
    set_presc(3, 2);
    req_i = 4'b1000;
    g = cyc + 1;
    push_gnt(g, 8);
    exp_tick.push_back(g + 3);
    push_snap(g + 7, 0, 1);
    push_snap(g + 8, 0, 0);
    goto(g + 6);
    req_i = '0;
    goto(g + 9);

`ifdef PRESC_ARB_TIMEOUT_EN
    // Scenario 6: forced release after TOT ticks, ownership passes to 1.
    set_presc(0, 1);
    set_presc(1, 1);
    req_i = 4'b0011;
    g = cyc + 1;
    push_gnt(g, 1);
    for (int k = 1; k <= 4; k++) exp_tick.push_back(g + 2*k);
    exp_to.push_back(g + 9);
    push_snap(g + 9, 0, 1);
    push_gnt(g + 11, 2);
    push_snap(g + 13, 0, 1);
    goto(g + 12);
    req_i = '0;
    goto(g + 15);
`else
    // Without the timeout feature a grant outlives TIMEOUT_TICKS ticks.
    set_presc(0, 0);
    req_i = 4'b0001;
    g = cyc + 1;
    push_gnt(g, 1);
    for (int k = 1; k <= 70; k++) exp_tick.push_back(g + k);
    push_snap(g + 72, 0, 1);
    goto(g + 71);
    req_i = '0;
    goto(g + 74);
`endif

    done = 1'b1;
  end

endmodule
